// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the dual-channel DAC SPI controller.
// Covers the FSM state encoding, shift-register op codes and frame geometry.
package dac_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SHIFT = 2'b10,
    OP_CLEAR = 2'b11
  } sr_op_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0]        cmd,
                                                    input logic [DATA_W-1:0] data);
    return {cmd, data};
  endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-in serial-out shift register, MSB first, with load/shift/clear ops.
module piso_reg
  import dac_ctrl_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  sr_op_t           op_i,
  input  logic [Width-1:0] load_i,
  output logic             msb_o
);

  logic [Width-1:0] sr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr <= '0;
    end else begin
      case (op_i)
        OP_LOAD:  sr <= load_i;
        OP_SHIFT: sr <= {sr[Width-2:0], 1'b0};
        OP_CLEAR: sr <= '0;
        default:  sr <= sr;
      endcase
    end
  end

  assign msb_o = sr[Width-1];

endmodule

// File: rtl/dac_spi_ctrl.sv
// Two-channel DAC write controller: per-channel request holding, round-robin
// arbitration and a mode-0 SPI frame engine (16-bit command+code frames).
module dac_spi_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned ClkDiv = 4,
  parameter logic [3:0]  CmdA   = 4'h3,
  parameter logic [3:0]  CmdB   = 4'h7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic              start_b_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic              busy_o,
  output logic              done_a_o,
  output logic              done_b_o,
  output logic              sclk_o,
  output logic              csn_o,
  output logic              mosi_o
);

  localparam logic [7:0] DivLast = 8'(ClkDiv - 1);

  state_t              state, state_nxt;
  sr_op_t              op;
  logic                pend_a, pend_b;
  logic [DATA_W-1:0]   hold_a, hold_b;
  logic [7:0]          div;
  logic [3:0]          bitcnt;
  logic                sclk;
  logic                rr_b;
  logic                sel_b;
  logic                grant;
  logic                grant_b;
  logic                div_end;
  logic [FRAME_W-1:0]  frame;

  // rr_b set means B has priority when both channels are pending
  assign grant_b = pend_b & (~pend_a | rr_b);
  assign div_end = (div == DivLast);
  assign frame   = grant_b ? make_frame(CmdB, hold_b) : make_frame(CmdA, hold_a);

  always_comb begin
    state_nxt = state;
    op        = OP_HOLD;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (pend_a || pend_b) begin
          grant     = 1'b1;
          op        = OP_LOAD;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: begin
        // falling SCLK edge: advance to the next bit
        if (div_end && sclk) begin
          op = OP_SHIFT;
          if (bitcnt == 4'd15) state_nxt = GAP;
        end
      end
      GAP: begin
        op = OP_CLEAR;
        if (div_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
      div    <= '0;
      bitcnt <= '0;
      sclk   <= 1'b0;
      rr_b   <= 1'b0;
      sel_b  <= 1'b0;
    end else begin
      state <= state_nxt;

      // a new request wins over the clear from a coincident grant
      if (start_a_i) begin
        pend_a <= 1'b1;
        hold_a <= data_a_i;
      end else if (grant && !grant_b) begin
        pend_a <= 1'b0;
      end

      if (start_b_i) begin
        pend_b <= 1'b1;
        hold_b <= data_b_i;
      end else if (grant && grant_b) begin
        pend_b <= 1'b0;
      end

      if (grant) begin
        sel_b <= grant_b;
        rr_b  <= ~grant_b;
      end

      if (state == SHIFT || state == GAP) div <= div_end ? 8'd0 : div + 8'd1;
      else                                div <= 8'd0;

      if (state == SHIFT && div_end) sclk <= ~sclk;

      if (op == OP_SHIFT) bitcnt <= bitcnt + 4'd1;
    end
  end

  piso_reg #(
    .Width (FRAME_W)
  ) u_piso (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .op_i   (op),
    .load_i (frame),
    .msb_o  (mosi_o)
  );

  assign busy_o   = (state != IDLE);
  assign csn_o    = !(state == LOAD || state == SHIFT);
  assign sclk_o   = sclk;
  assign done_a_o = (state == GAP) && div_end && !sel_b;
  assign done_b_o = (state == GAP) && div_end && sel_b;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Self-checking bench for dac_spi_ctrl: directed and random requests checked
// against a request-level model of the arbitration and frame format.
module tb_dac_spi_ctrl;

  localparam int          CLK_DIV = 4;
  localparam logic [3:0]  CMD_A   = 4'h3;
  localparam logic [3:0]  CMD_B   = 4'h7;
  localparam int          LOW_CYC = 1 + 2 * 16 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [11:0] data_a = '0, data_b = '0;
  logic        busy, done_a, done_b, sclk, csn, mosi;

  always #5 clk = ~clk;

  dac_spi_ctrl #(
    .ClkDiv (CLK_DIV),
    .CmdA   (CMD_A),
    .CmdB   (CMD_B)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_a_i (start_a),
    .data_a_i  (data_a),
    .start_b_i (start_b),
    .data_b_i  (data_b),
    .busy_o    (busy),
    .done_a_o  (done_a),
    .done_b_o  (done_b),
    .sclk_o    (sclk),
    .csn_o     (csn),
    .mosi_o    (mosi)
  );

  int vectors = 0;
  int miscompares = 0;

  // request-level model: pending/data per channel, last channel served
  bit          m_pend[2];
  logic [11:0] m_data[2];
  int          m_last = -1;
  logic [16:0] exp_q[$];

  // bus observations
  logic [15:0] cap_q[$];
  int          low_q[$], rise_q[$], done_q[$], dgap_q[$];
  int          started = 0, cur_rises = 0, low_cnt = 0, hi_cnt = 0;
  logic [15:0] sh = '0;
  logic        prev_csn = 1'b1, prev_sclk = 1'b0;

  function automatic void m_serve();
    int win;
    if (!m_pend[0] && !m_pend[1]) begin
      exp_q.push_back(17'h1FFFF);
      return;
    end
    if (m_pend[0] && m_pend[1]) win = (m_last == 0) ? 1 : 0;
    else                        win = m_pend[1] ? 1 : 0;
    m_pend[win] = 1'b0;
    m_last      = win;
    exp_q.push_back({1'(win), (win == 1) ? CMD_B : CMD_A, m_data[win]});
  endfunction

  function automatic void m_reset();
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    m_last    = -1;
    exp_q.delete();
    cap_q.delete(); low_q.delete(); rise_q.delete();
    done_q.delete(); dgap_q.delete();
  endfunction

  always @(negedge clk) begin
    if (!csn) begin
      if (prev_csn) begin
        started++;
        low_cnt   = 0;
        cur_rises = 0;
        sh        = '0;
        m_serve();
      end
      low_cnt++;
      if (sclk && !prev_sclk) begin
        sh = {sh[14:0], mosi};
        cur_rises++;
      end
    end else begin
      if (!prev_csn) begin
        cap_q.push_back(sh);
        low_q.push_back(low_cnt);
        rise_q.push_back(cur_rises);
        hi_cnt = 0;
      end
      hi_cnt++;
    end
    if (done_a) begin done_q.push_back(0); dgap_q.push_back(hi_cnt); end
    if (done_b) begin done_q.push_back(1); dgap_q.push_back(hi_cnt); end
    prev_csn  = csn;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit a, input logic [11:0] da, input bit b, input logic [11:0] db);
    @(negedge clk); #1;
    start_a = a;
    start_b = b;
    if (a) begin data_a = da; m_pend[0] = 1'b1; m_data[0] = da; end
    if (b) begin data_b = db; m_pend[1] = 1'b1; m_data[1] = db; end
    @(negedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_started(input int n, input string tag);
    int i = 0;
    while (started < n && i < 2000) begin @(negedge clk); #1; i++; end
    chk({tag, "_start_timeout"}, 32'(started >= n), 1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    int i = 0;
    while (cur_rises < n && i < 1000) begin @(negedge clk); #1; i++; end
    chk({tag, "_rise_timeout"}, 32'(cur_rises >= n), 1);
  endtask

  task automatic wait_quiet(input string tag);
    int idle = 0;
    int i = 0;
    while (idle < 6 && i < 4000) begin
      @(negedge clk); #1;
      idle = busy ? 0 : idle + 1;
      i++;
    end
    chk({tag, "_quiet_timeout"}, 32'(idle >= 6), 1);
  endtask

  task automatic check_all(input string tag, input int n);
    logic [16:0] e;
    chk({tag, "_nframes"}, cap_q.size(), n);
    chk({tag, "_nexpect"}, exp_q.size(), n);
    chk({tag, "_ndone"},   done_q.size(), n);
    while (cap_q.size() > 0 && exp_q.size() > 0 && done_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_frame"}, cap_q.pop_front(), e[15:0]);
      chk({tag, "_chan"},  done_q.pop_front(), e[16]);
      chk({tag, "_csn_low"}, low_q.pop_front(), LOW_CYC);
      chk({tag, "_rises"}, rise_q.pop_front(), 16);
      chk({tag, "_done_pos"}, dgap_q.pop_front(), CLK_DIV);
    end
    m_reset_queues();
  endtask

  function automatic void m_reset_queues();
    exp_q.delete();
    cap_q.delete(); low_q.delete(); rise_q.delete();
    done_q.delete(); dgap_q.delete();
  endfunction

  task automatic pulse_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [11:0] ra, rb;
    int pat, s;

    // reset values, with a start coincident with reset that must be dropped
    start_a = 1'b1;
    data_a  = 12'h5A5;
    repeat (3) @(negedge clk);
    chk("rst_csn", csn, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_done_b", done_b, 0);
    #1 rst = 1'b0;
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_start_dropped", started, 0);

    // single channel A frame with start latency
    req(1'b1, 12'hABC, 1'b0, 12'h000);
    chk("lat_pending_csn", csn, 1);
    @(negedge clk); #1;
    chk("lat_csn_low", csn, 0);
    chk("lat_busy", busy, 1);
    wait_quiet("single");
    check_all("single", 1);

    // simultaneous requests straight after reset: A first
    pulse_reset();
    req(1'b1, 12'h001, 1'b1, 12'hFFF);
    wait_quiet("simul");
    if (cap_q.size() == 2) begin
      chk("simul_first", cap_q[0], 16'h3001);
      chk("simul_second", cap_q[1], 16'h7FFF);
    end else begin
      chk("simul_count", cap_q.size(), 2);
    end
    check_all("simul", 2);

    // continuous contention: both re-requested during each frame
    s = started;
    req(1'b1, 12'($urandom), 1'b1, 12'($urandom));
    for (int k = 0; k < 4; k++) begin
      wait_started(s + k + 1, "contend");
      wait_rises(3, "contend");
      req(1'b1, 12'($urandom), 1'b1, 12'($urandom));
    end
    wait_quiet("contend");
    check_all("contend", 6);

    // overwrite of a pending A request during a B frame
    s = started;
    req(1'b0, 12'h000, 1'b1, 12'($urandom));
    wait_started(s + 1, "ovw");
    wait_rises(2, "ovw");
    req(1'b1, 12'h111, 1'b0, 12'h000);
    wait_rises(6, "ovw");
    req(1'b1, 12'h222, 1'b0, 12'h000);
    wait_quiet("ovw");
    if (cap_q.size() == 2) chk("ovw_a_frame", cap_q[1], 16'h3222);
    else                   chk("ovw_count", cap_q.size(), 2);
    check_all("ovw", 2);

    // request on the channel currently in flight
    s = started;
    req(1'b1, 12'h123, 1'b0, 12'h000);
    wait_started(s + 1, "mid");
    wait_rises(5, "mid");
    req(1'b1, 12'h555, 1'b0, 12'h000);
    wait_quiet("mid");
    if (cap_q.size() == 2) begin
      chk("mid_first", cap_q[0], 16'h3123);
      chk("mid_second", cap_q[1], 16'h3555);
    end else begin
      chk("mid_count", cap_q.size(), 2);
    end
    check_all("mid", 2);

    // randomized single and paired requests
    for (int k = 0; k < 6; k++) begin
      pat = $urandom_range(1, 3);
      ra  = 12'($urandom);
      rb  = 12'($urandom);
      req(pat[0], ra, pat[1], rb);
      wait_quiet("rand");
      check_all("rand", (pat == 3) ? 2 : 1);
    end

    // reset in the middle of a frame, with a start coincident with reset
    s = started;
    req(1'b1, 12'($urandom), 1'b0, 12'h000);
    wait_started(s + 1, "rmid");
    wait_rises(7, "rmid");
    @(negedge clk); #1;
    rst     = 1'b1;
    start_b = 1'b1;
    data_b  = 12'($urandom);
    @(negedge clk);
    chk("rmid_csn", csn, 1);
    chk("rmid_sclk", sclk, 0);
    chk("rmid_mosi", mosi, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_done", {done_a, done_b}, 0);
    #1;
    rst     = 1'b0;
    start_b = 1'b0;
    chk("rmid_no_done", done_q.size(), 0);
    m_reset();
    s = started;
    repeat (300) @(negedge clk);
    chk("rmid_no_frame", started, s);
    chk("rmid_no_done_after", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
